// File: rtl/exception_ctrl_pkg.sv
// Shared definitions for the MEM-stage exception unit: exception codes,
// CP0 register addresses, the default exception vector and FSM states.
package exception_ctrl_pkg;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam logic [31:0] EXC_NONE = 32'h0;
  localparam logic [31:0] EXC_INT  = 32'h1;
  localparam logic [31:0] EXC_ADEL = 32'h4;
  localparam logic [31:0] EXC_ADES = 32'h5;
  localparam logic [31:0] EXC_SYS  = 32'h8;
  localparam logic [31:0] EXC_BP   = 32'h9;
  localparam logic [31:0] EXC_RI   = 32'hA;
  localparam logic [31:0] EXC_OV   = 32'hC;
  localparam logic [31:0] EXC_TR   = 32'hD;
  localparam logic [31:0] EXC_ERET = 32'hE;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_t;

endpackage

// File: rtl/except_prio.sv
// Fixed-priority exception selector: returns the winning exception code
// and the bad address that goes with it. Purely combinational.
module except_prio
  import exception_ctrl_pkg::*;
(
  input  logic        int_pending,
  input  logic        adel_if,
  input  logic        ri,
  input  logic        syscall,
  input  logic        brk,
  input  logic        ov,
  input  logic        trap,
  input  logic        adel_ld,
  input  logic        ades_st,
  input  logic        eret,
  input  logic [31:0] pc,
  input  logic [31:0] mem_addr,
  output logic [31:0] excepttype,
  output logic [31:0] bad_addr
);

  always_comb begin
    excepttype = EXC_NONE;
    bad_addr   = 32'h0;
    // Interrupts preempt everything, including eret.
    if (int_pending) begin
      excepttype = EXC_INT;
    end else if (adel_if) begin
      excepttype = EXC_ADEL;
      bad_addr   = pc;
    end else if (ri) begin
      excepttype = EXC_RI;
    end else if (syscall) begin
      excepttype = EXC_SYS;
    end else if (brk) begin
      excepttype = EXC_BP;
    end else if (ov) begin
      excepttype = EXC_OV;
    end else if (trap) begin
      excepttype = EXC_TR;
    end else if (adel_ld) begin
      excepttype = EXC_ADEL;
      bad_addr   = mem_addr;
    end else if (ades_st) begin
      excepttype = EXC_ADES;
      bad_addr   = mem_addr;
    end else if (eret) begin
      excepttype = EXC_ERET;
    end
  end

endmodule

// File: rtl/exception_ctrl.sv
// MEM-stage exception arbitration: forwards pending CP0 writes, reports the
// winning exception to CP0, flushes the pipeline and offers a redirect PC.
module exception_ctrl
  import exception_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        mem_valid_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] mem_addr_i,
  input  logic        adel_if_i,
  input  logic        ri_i,
  input  logic        syscall_i,
  input  logic        break_i,
  input  logic        ov_i,
  input  logic        trap_i,
  input  logic        adel_ld_i,
  input  logic        ades_st_i,
  input  logic        eret_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        cp0_we_i,
  input  logic [4:0]  cp0_waddr_i,
  input  logic [31:0] cp0_wdata_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] epc_pc_o,
  output logic        in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ready_i
);

  state_t      state_reg, state_next;
  logic [31:0] redir_pc_reg, redir_pc_next;

  logic [31:0] status_eff, epc_eff;
  logic [15:8] cause_ip_eff;
  logic        int_pending;
  logic [31:0] prio_code, prio_bad_addr;
  logic        candidate, launch;

  always_comb begin
    status_eff   = (cp0_we_i && cp0_waddr_i == CP0_STATUS) ? cp0_wdata_i : status_i;
    epc_eff      = (cp0_we_i && cp0_waddr_i == CP0_EPC)    ? cp0_wdata_i : epc_i;
    // Only the software interrupt bits of CAUSE are writable.
    cause_ip_eff = {cause_i[15:10],
                    (cp0_we_i && cp0_waddr_i == CP0_CAUSE) ? cp0_wdata_i[9:8] : cause_i[9:8]};
  end

  logic unused_bits;
  assign unused_bits = ^{status_eff[31:16], status_eff[7:2], cause_i[31:16], cause_i[7:0]};

  assign int_pending = status_eff[0] & ~status_eff[1] & (|(cause_ip_eff & status_eff[15:8]));

  except_prio u_prio (
    .int_pending (int_pending),
    .adel_if     (adel_if_i),
    .ri          (ri_i),
    .syscall     (syscall_i),
    .brk         (break_i),
    .ov          (ov_i),
    .trap        (trap_i),
    .adel_ld     (adel_ld_i),
    .ades_st     (ades_st_i),
    .eret        (eret_i),
    .pc          (pc_i),
    .mem_addr    (mem_addr_i),
    .excepttype  (prio_code),
    .bad_addr    (prio_bad_addr)
  );

  assign candidate = mem_valid_i & ~stall_i & ~rst & (state_reg == IDLE);
  assign launch    = candidate & (prio_code != EXC_NONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      redir_pc_reg <= 32'h0;
    end else begin
      state_reg    <= state_next;
      redir_pc_reg <= redir_pc_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    redir_pc_next    = redir_pc_reg;
    excepttype_o     = EXC_NONE;
    epc_pc_o         = 32'h0;
    in_delayslot_o   = 1'b0;
    bad_addr_o       = 32'h0;
    flush_o          = 1'b0;
    redirect_valid_o = 1'b0;
    case (state_reg)
      IDLE: begin
        if (launch) begin
          excepttype_o   = prio_code;
          epc_pc_o       = pc_i;
          in_delayslot_o = in_delayslot_i;
          bad_addr_o     = prio_bad_addr;
          flush_o        = 1'b1;
          redir_pc_next  = (prio_code == EXC_ERET) ? epc_eff : EXC_VECTOR;
          state_next     = REDIRECT;
        end
      end
      REDIRECT: begin
        redirect_valid_o = 1'b1;
        if (redirect_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign redirect_pc_o = redir_pc_reg;

endmodule
